// File: rtl/seq_mac_unit.sv
// Sequential shift-and-add unsigned MAC: one operand pair per handshake, result on `last`.
// Define SEQ_MAC_SAT_EN to saturate the accumulator instead of wrapping.

module FullAdder1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// N-bit ripple-carry adder; s[N] is the carry-out.
module seq_mac_rca #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N:0]   s
);
  logic [N:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_fa
    FullAdder1bit u_fa (
      .a   (x[i]),
      .b   (y[i]),
      .cin (c[i]),
      .sum (s[i]),
      .cout(c[i+1])
    );
  end

  assign s[N] = c[N];
endmodule

module seq_mac_unit #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 first,
  input  logic                 last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc_out
);
  // state | meaning
  // IDLE  | waiting for an operand pair
  // MULT  | one multiplier bit per cycle, WIDTH cycles
  // ACC   | fold product into the accumulator
  // OUT   | result presented, waiting for out_ready

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MULT, ACC, OUT} state_t;

  state_t               state;
  logic [PW-1:0]        mcand;
  logic [WIDTH-1:0]     mplier;
  logic [PW-1:0]        prod;
  logic [CW-1:0]        cnt;
  logic                 first_r;
  logic                 last_r;
  logic [ACC_WIDTH-1:0] acc;

  logic [PW:0]          prod_sum;
  logic [ACC_WIDTH-1:0] acc_base;
  logic [ACC_WIDTH:0]   acc_sum;
  logic [ACC_WIDTH-1:0] acc_next;

  seq_mac_rca #(.N(PW)) u_prod_add (
    .x(prod),
    .y(mcand),
    .s(prod_sum)
  );

  assign acc_base = first_r ? '0 : acc;

  seq_mac_rca #(.N(ACC_WIDTH)) u_acc_add (
    .x(acc_base),
    .y(ACC_WIDTH'(prod)),
    .s(acc_sum)
  );

`ifdef SEQ_MAC_SAT_EN
  assign acc_next = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
`else
  assign acc_next = ACC_WIDTH'(acc_sum);
`endif

  assign acc_out = acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      cnt       <= '0;
      first_r   <= 1'b0;
      last_r    <= 1'b0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= PW'(a);
            mplier   <= b;
            first_r  <= first;
            last_r   <= last;
            prod     <= '0;
            cnt      <= CW'(WIDTH - 1);
            in_ready <= 1'b0;
            state    <= MULT;
          end
        end
        MULT: begin
          // multiplicand shifts left and multiplier right, so bit i meets a<<i
          if (mplier[0]) prod <= PW'(prod_sum);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == '0) state <= ACC;
        end
        ACC: begin
          acc <= acc_next;
          if (last_r) begin
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
